y_issue_scheduler: RTL and testbench

//  Issue-side scheduler for the single-cycle X pipe and the Y_LAT-stage Y pipe (Y0..Y3).

---
 rtl/y_issue_scheduler_if.sv | 22 ++
 rtl/y_issue_scheduler.sv | 84 ++++++++
 tb/tb_y_issue_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/y_issue_scheduler_if.sv
// Issue-stage handshake between the instruction issue slot and the X/Y scheduler.
// The issue stage drives the instruction fields; the scheduler answers with accept and stall cause.
interface y_issue_scheduler_if;
  logic       is_valid;
  logic       is_unit;
  logic [4:0] is_rs;
  logic [4:0] is_rt;
  logic [4:0] is_regdest;
  logic       is_writereg;
  logic       is_accept;
  logic [1:0] stall_cause;

  modport master (
    output is_valid, is_unit, is_rs, is_rt, is_regdest, is_writereg,
    input  is_accept, stall_cause
  );

  modport slave (
    input  is_valid, is_unit, is_rs, is_rt, is_regdest, is_writereg,
    output is_accept, stall_cause
  );
endinterface

// File: rtl/y_issue_scheduler.sv
// Single-issue scheduler for a 1-cycle X pipe and a Y_LAT-stage Y pipe: tracks in-flight
// Y ops in a shifting scoreboard and stalls issue on RAW, WAW and writeback-port hazards.
module y_issue_scheduler #(
  parameter int Y_LAT = 4,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  y_issue_scheduler_if.slave  iss,
  output logic [Y_LAT-1:0]    y_slot_valid,
  output logic                wb_sel_y,
  output logic [CNT_W-1:0]    stall_count
);

  logic [Y_LAT-1:0] valid_reg;
  logic [Y_LAT-1:0] wr_reg;
  logic [4:0]       rd_reg [Y_LAT];
  logic             wb_sel_reg;
  logic [CNT_W-1:0] stall_count_reg;

  logic [Y_LAT-1:0] live;
  logic [Y_LAT-1:0] raw_hit;
  logic [Y_LAT-1:0] waw_hit;
  logic             x_writes;
  logic [1:0]       cause_next;
  logic             accept_next;
  logic             y_load;

  // Every live slot is checked, including the one writing back this cycle: no bypass exists.
  for (genvar gi = 0; gi < Y_LAT; gi++) begin : g_slot
    assign live[gi]    = valid_reg[gi] & wr_reg[gi] & (rd_reg[gi] != 5'd0);
    assign raw_hit[gi] = live[gi] &
                         (((iss.is_rs != 5'd0) && (iss.is_rs == rd_reg[gi])) ||
                          ((iss.is_rt != 5'd0) && (iss.is_rt == rd_reg[gi])));
    assign waw_hit[gi] = live[gi] & (iss.is_regdest == rd_reg[gi]);
  end

  assign x_writes = ~iss.is_unit & iss.is_writereg;

  always_comb begin
    cause_next = 2'd0;
    if (iss.is_valid) begin
      if (|raw_hit)
        cause_next = 2'd1;
      else if (x_writes && (iss.is_regdest != 5'd0) && (|waw_hit))
        cause_next = 2'd2;
      else if (x_writes && live[Y_LAT-2])
        cause_next = 2'd3;
    end
    accept_next = iss.is_valid & (cause_next == 2'd0);
    y_load      = accept_next & iss.is_unit;
  end

  assign iss.stall_cause = cause_next;
  assign iss.is_accept   = accept_next;

  // The Y pipe never back-pressures, so the scoreboard shifts unconditionally every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg       <= '0;
      wr_reg          <= '0;
      wb_sel_reg      <= 1'b0;
      stall_count_reg <= '0;
      for (int k = 0; k < Y_LAT; k++) rd_reg[k] <= 5'd0;
    end else begin
      valid_reg[0] <= y_load;
      wr_reg[0]    <= iss.is_writereg;
      rd_reg[0]    <= iss.is_regdest;
      for (int k = 1; k < Y_LAT; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        wr_reg[k]    <= wr_reg[k-1];
        rd_reg[k]    <= rd_reg[k-1];
      end
      wb_sel_reg <= live[Y_LAT-2];
      if (iss.is_valid && !accept_next && (stall_count_reg != {CNT_W{1'b1}}))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign y_slot_valid = valid_reg;
  assign wb_sel_y     = wb_sel_reg;
  assign stall_count  = stall_count_reg;

endmodule

// File: tb/tb_y_issue_scheduler.sv
// Directed and randomized checks of y_issue_scheduler against a time-stamped list of
// in-flight Y ops; a second instance with a 2-bit counter exercises saturation.
module tb_y_issue_scheduler;
  localparam int YL = 4;

  typedef struct {
    int         t;
    logic [4:0] rd;
    logic       wr;
  } yop_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  y_issue_scheduler_if ifc ();
  y_issue_scheduler_if ifc2 ();

  logic [YL-1:0] slots, slots2;
  logic          wb, wb2;
  logic [15:0]   cnt;
  logic [1:0]    cnt2;

  assign ifc2.is_valid    = ifc.is_valid;
  assign ifc2.is_unit     = ifc.is_unit;
  assign ifc2.is_rs       = ifc.is_rs;
  assign ifc2.is_rt       = ifc.is_rt;
  assign ifc2.is_regdest  = ifc.is_regdest;
  assign ifc2.is_writereg = ifc.is_writereg;

  y_issue_scheduler #(.Y_LAT(YL), .CNT_W(16)) dut (
    .clock(clk), .reset(reset), .iss(ifc.slave),
    .y_slot_valid(slots), .wb_sel_y(wb), .stall_count(cnt)
  );

  y_issue_scheduler #(.Y_LAT(YL), .CNT_W(2)) dut2 (
    .clock(clk), .reset(reset), .iss(ifc2.slave),
    .y_slot_valid(slots2), .wb_sel_y(wb2), .stall_count(cnt2)
  );

  yop_t          q[$];
  int            cyc;
  int            exp_cnt;
  int            errors;
  int            checks;
  logic [1:0]    last_cause;
  logic          last_acc;
  logic          last_wb;
  logic [YL-1:0] last_slots;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hazards derived from each op's age: an op accepted at cycle t sits in stage cyc-t-1.
  function automatic logic [1:0] m_cause(input logic v, input logic u, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic w);
    logic raw = 1'b0;
    logic waw = 1'b0;
    logic wbp = 1'b0;
    if (!v) return 2'd0;
    foreach (q[i]) begin
      int s = cyc - q[i].t - 1;
      if (q[i].wr && q[i].rd != 5'd0 && s >= 0 && s < YL) begin
        if ((rs != 5'd0 && rs == q[i].rd) || (rt != 5'd0 && rt == q[i].rd)) raw = 1'b1;
        if (!u && w && rd != 5'd0 && rd == q[i].rd) waw = 1'b1;
        if (!u && w && s == YL - 2) wbp = 1'b1;
      end
    end
    if (raw) return 2'd1;
    if (waw) return 2'd2;
    if (wbp) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [YL-1:0] m_slots();
    logic [YL-1:0] r = '0;
    foreach (q[i]) begin
      int s = cyc - q[i].t - 1;
      if (s >= 0 && s < YL) r[s] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic m_wb();
    logic r = 1'b0;
    foreach (q[i]) begin
      int s = cyc - q[i].t - 1;
      if (s == YL - 1 && q[i].wr && q[i].rd != 5'd0) r = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input logic v, input logic u, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic w, input logic rst);
    logic [1:0] ec;
    logic       ea;
    @(negedge clk);
    reset           = rst;
    ifc.is_valid    = v;
    ifc.is_unit     = u;
    ifc.is_rs       = rs;
    ifc.is_rt       = rt;
    ifc.is_regdest  = rd;
    ifc.is_writereg = w;
    #1;
    ec = m_cause(v, u, rs, rt, rd, w);
    ea = v && (ec == 2'd0);
    last_cause = ifc.stall_cause;
    last_acc   = ifc.is_accept;
    last_wb    = wb;
    last_slots = slots;
    if (!rst) begin
      chk("stall_cause", 32'(ifc.stall_cause), 32'(ec));
      chk("is_accept", 32'(ifc.is_accept), 32'(ea));
      chk("is_accept_cnt2", 32'(ifc2.is_accept), 32'(ea));
    end
    chk("y_slot_valid", 32'(slots), 32'(m_slots()));
    chk("wb_sel_y", 32'(wb), 32'(m_wb()));
    chk("stall_count", 32'(cnt), 32'(exp_cnt));
    chk("stall_count_sat", 32'(cnt2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_cnt = 0;
    end else begin
      if (ea && u) q.push_back('{t: cyc, rd: rd, wr: w});
      if (v && !ea && exp_cnt < 65535) exp_cnt++;
    end
    cyc++;
    while (q.size() > 0 && (cyc - q[0].t - 1) >= YL) void'(q.pop_front());
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int wb_hi;
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    exp_cnt = 0;
    reset           = 1'b1;
    ifc.is_valid    = 1'b0;
    ifc.is_unit     = 1'b0;
    ifc.is_rs       = 5'd0;
    ifc.is_rt       = 5'd0;
    ifc.is_regdest  = 5'd0;
    ifc.is_writereg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_slots", 32'(slots), 32'd0);
    chk("reset_wb", 32'(wb), 32'd0);
    chk("reset_cnt", 32'(cnt), 32'd0);

    // 1: RAW against Y rd=5
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    repeat (4) begin
      step(1'b0 | 1'b1, 1'b0, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0);
      chk("t1_raw", 32'(last_cause), 32'd1);
    end
    step(1'b1, 1'b0, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0);
    chk("t1_accept", 32'(last_acc), 32'd1);
    #1 chk("t1_count", 32'(cnt), 32'd4);

    // 2: WAW against Y rd=7
    do_reset();
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    repeat (4) begin
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
      chk("t2_waw", 32'(last_cause), 32'd2);
    end
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    chk("t2_accept", 32'(last_acc), 32'd1);

    // 3: writeback port collision
    do_reset();
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    repeat (2) begin
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
      chk("t3_accept_early", 32'(last_acc), 32'd1);
    end
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    chk("t3_wb_stall", 32'(last_cause), 32'd3);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    chk("t3_retry_accept", 32'(last_acc), 32'd1);
    chk("t3_wb_sel", 32'(last_wb), 32'd1);

    // 4: back-to-back Y ops
    do_reset();
    wb_hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) step(1'b1, 1'b1, 5'd0, 5'd0, 5'(i + 1), 1'b1, 1'b0);
      else idle();
      if (i < 10) chk("t4_accept", 32'(last_acc), 32'd1);
      if (i >= 4 && i < 10) chk("t4_full", 32'(last_slots), 32'hF);
      if (last_wb) wb_hi++;
    end
    chk("t4_wb_cycles", 32'(wb_hi), 32'd10);

    // 5: non-writing Y ops never cause hazards
    do_reset();
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b1, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
      chk("t5_no_stall", 32'(last_cause), 32'd0);
    end

    // 6: reset with ops in flight, then counter saturation
    do_reset();
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    idle();
    do_reset();
    chk("t6_pre_reset_slots", 32'(last_slots), 32'b0110);
    #1;
    chk("t6_slots", 32'(slots), 32'd0);
    chk("t6_wb", 32'(wb), 32'd0);
    chk("t6_cnt", 32'(cnt), 32'd0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 5'd0, 5'd5, 5'd2, 1'b1, 1'b0);
    #1;
    chk("t6_sat", 32'(cnt2), 32'd3);
    chk("t6_full_cnt", 32'(cnt), 32'd4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
